// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared register-file writeback definitions
package cpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_req_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_ALU,
    GNT_MEM
  } gnt_src_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - synchronous FIFO of writeback requests with registered full/empty/count
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  wb_req_t          push_req,
  input  logic             pop,
  output wb_req_t          head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  wb_req_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;

  // DEPTH is a power of two, so pointers wrap by natural overflow
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    full_d   = (count_d == CNT_W'(DEPTH));
    empty_d  = (count_d == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_req;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;
  assign count = count_q;

endmodule

// File: rtl/rf_writeback_ctrl.sv
// rtl/rf_writeback_ctrl.sv - register file write port owner: ALU/load arbiter and load scoreboard
module rf_writeback_ctrl #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              ld_issue,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [ADDR_W-1:0] q_addr1,
  input  logic [ADDR_W-1:0] q_addr2,
  output logic              q_busy1,
  output logic              q_busy2,
  output logic              rf_wr,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_data
);

  import cpu_pkg::*;

  localparam int SC_W  = $clog2(STARVE_MAX + 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int NREG  = 1 << ADDR_W;

  gnt_src_t          gnt;
  wb_req_t           alu_req, mem_req, fifo_head, win;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [SC_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic              rf_wr_q, rf_wr_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0] rf_data_q, rf_data_d;

  assign alu_req.addr = alu_addr;
  assign alu_req.data = alu_data;
  assign mem_req.addr = mem_addr;
  assign mem_req.data = mem_data;

  assign fifo_push = mem_valid && !fifo_full;
  assign fifo_pop  = (gnt == GNT_MEM);

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .push_req (mem_req),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // A full buffer or a starved head pre-empts the ALU; otherwise the ALU has priority
  always_comb begin
    gnt = GNT_NONE;
    if (!fifo_empty && (fifo_full || starve_cnt_q == SC_W'(STARVE_MAX))) begin
      gnt = GNT_MEM;
    end else if (alu_valid) begin
      gnt = GNT_ALU;
    end else if (!fifo_empty) begin
      gnt = GNT_MEM;
    end
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (fifo_count == '0 || gnt == GNT_MEM) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != SC_W'(STARVE_MAX)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_comb begin
    win       = (gnt == GNT_MEM) ? fifo_head : alu_req;
    rf_wr_d   = (gnt != GNT_NONE) && (win.addr != '0);
    rf_addr_d = rf_wr_d ? win.addr : rf_addr_q;
    rf_data_d = rf_wr_d ? win.data : rf_data_q;
  end

  // Clear first so a same-edge issue to the same register keeps it pending
  always_comb begin
    busy_d = busy_q;
    if (gnt == GNT_MEM) begin
      busy_d[fifo_head.addr] = 1'b0;
    end
    if (ld_issue) begin
      busy_d[ld_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt_q <= '0;
      busy_q       <= '0;
      rf_wr_q      <= 1'b0;
      rf_addr_q    <= '0;
      rf_data_q    <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      busy_q       <= busy_d;
      rf_wr_q      <= rf_wr_d;
      rf_addr_q    <= rf_addr_d;
      rf_data_q    <= rf_data_d;
    end
  end

  assign alu_ready = alu_valid && (gnt == GNT_ALU);
  assign mem_ready = !fifo_full;
  assign q_busy1   = busy_q[q_addr1];
  assign q_busy2   = busy_q[q_addr2];
  assign rf_wr     = rf_wr_q;
  assign rf_addr   = rf_addr_q;
  assign rf_data   = rf_data_q;

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// tb/tb_rf_writeback_ctrl.sv - self-checking bench for rf_writeback_ctrl
module tb_rf_writeback_ctrl;
  import cpu_pkg::*;

  localparam int DEPTH = 4;
  localparam int SMAX  = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        mem_valid, mem_ready;
  logic [4:0]  mem_addr;
  logic [31:0] mem_data;
  logic        ld_issue;
  logic [4:0]  ld_addr, q_addr1, q_addr2;
  logic        q_busy1, q_busy2;
  logic        rf_wr;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;

  always #5 clk = ~clk;

  rf_writeback_ctrl #(
    .DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .ld_issue(ld_issue), .ld_addr(ld_addr),
    .q_addr1(q_addr1), .q_addr2(q_addr2), .q_busy1(q_busy1), .q_busy2(q_busy2),
    .rf_wr(rf_wr), .rf_addr(rf_addr), .rf_data(rf_data)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // reference model: load buffer as a queue, pending bits as an array
  wb_req_t     mq[$];
  int          m_starve;
  bit          m_busy[32];
  bit          e_wr;
  logic [4:0]  e_addr;
  logic [31:0] e_data;
  int          last_gnt;
  bit          last_push;
  logic        s_alu_ready;

  typedef struct {
    bit          v;
    logic [4:0]  a;
    logic [31:0] d;
    bit          rdy;
    bit          wr;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, exp);
    end
  endtask

  // 0 = no grant, 1 = ALU, 2 = load buffer
  function automatic int pick(input bit av);
    if (mq.size() > 0 && (mq.size() == DEPTH || m_starve == SMAX)) return 2;
    if (av) return 1;
    if (mq.size() > 0) return 2;
    return 0;
  endfunction

  task automatic idle();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    ld_issue  = 1'b0;
  endtask

  task automatic step();
    int      g;
    int      sz;
    bit      push;
    wb_req_t w;
    #2;
    sz   = mq.size();
    g    = pick(alu_valid);
    push = mem_valid && (sz < DEPTH);
    s_alu_ready = alu_ready;
    chk("alu_ready", alu_ready, (alu_valid && g == 1));
    chk("mem_ready", mem_ready, (sz < DEPTH));
    chk("q_busy1", q_busy1, m_busy[q_addr1]);
    chk("q_busy2", q_busy2, m_busy[q_addr2]);
    w.addr = alu_addr;
    w.data = alu_data;
    if (g == 2) w = mq[0];
    @(posedge clk);
    e_wr = (g != 0) && (w.addr != 0);
    if (e_wr) begin
      e_addr = w.addr;
      e_data = w.data;
    end
    if (g == 2) begin
      m_busy[w.addr] = 1'b0;
      void'(mq.pop_front());
    end
    if (push) begin
      w.addr = mem_addr;
      w.data = mem_data;
      mq.push_back(w);
    end
    if (ld_issue && ld_addr != 0) m_busy[ld_addr] = 1'b1;
    if (sz == 0 || g == 2) m_starve = 0;
    else if (m_starve < SMAX) m_starve++;
    last_gnt  = g;
    last_push = push;
    #1;
    cyc++;
    chk("rf_wr", rf_wr, e_wr);
    if (e_wr) begin
      chk("rf_addr", rf_addr, e_addr);
      chk("rf_data", rf_data, e_data);
    end
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    mq.delete();
    m_starve = 0;
    foreach (m_busy[k]) m_busy[k] = 1'b0;
    e_wr = 1'b0;
    #1;
    chk("rst_rf_wr", rf_wr, 0);
    chk("rst_rf_addr", rf_addr, 0);
    chk("rst_rf_data", rf_data, 0);
    chk("rst_mem_ready", mem_ready, 1);
    chk("rst_q_busy1", q_busy1, 0);
    chk("rst_q_busy2", q_busy2, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic issue(input logic [4:0] a);
    idle();
    ld_issue = 1'b1;
    ld_addr  = a;
    step();
    ld_issue = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int          wins;
    int          fifo_cycle;
    int          wrcnt;
    logic [4:0]  got[$];
    bit          outst[32];
    int          cands[$];

    reset = 1'b0;
    idle();
    alu_addr = '0; alu_data = '0; mem_addr = '0; mem_data = '0;
    ld_addr = '0; q_addr1 = '0; q_addr2 = '0;
    last_gnt = 0; last_push = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // ALU write appears one edge later, then drops
    alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
    step();
    chk("t1_wr", rf_wr, 1);
    chk("t1_addr", rf_addr, 5);
    chk("t1_data", rf_data, 32'hDEADBEEF);
    idle();
    step();
    chk("t1_wr_off", rf_wr, 0);

    tbl[0] = '{1'b1, 5'd1,  32'h0000_0001, 1'b1, 1'b1};
    tbl[1] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1, 1'b1};
    tbl[2] = '{1'b0, 5'd4,  32'h0000_00AA, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 5'd0,  32'h0000_0055, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 5'd16, 32'h8000_0000, 1'b1, 1'b1};
    tbl[5] = '{1'b1, 5'd2,  32'h0000_0000, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      alu_valid = tbl[i].v; alu_addr = tbl[i].a; alu_data = tbl[i].d;
      step();
      chk("tbl_ready", s_alu_ready, tbl[i].rdy);
      chk("tbl_wr", rf_wr, tbl[i].wr);
      if (tbl[i].wr) begin
        chk("tbl_addr", rf_addr, tbl[i].a);
        chk("tbl_data", rf_data, tbl[i].d);
      end
    end
    idle();

    // load path: pending bit, two-edge latency, clear on write
    issue(5'd7);
    q_addr1 = 5'd7;
    #1;
    chk("t2_busy", q_busy1, 1);
    mem_valid = 1'b1; mem_addr = 5'd7; mem_data = 32'h12345678;
    step();
    mem_valid = 1'b0;
    chk("t2_no_early", rf_wr, 0);
    chk("t2_busy_hold", q_busy1, 1);
    step();
    chk("t2_wr", rf_wr, 1);
    chk("t2_addr", rf_addr, 7);
    chk("t2_data", rf_data, 32'h12345678);
    chk("t2_busy_clr", q_busy1, 0);

    // starvation limit
    issue(5'd3);
    alu_valid = 1'b1; alu_addr = 5'd20; alu_data = 32'h0;
    mem_valid = 1'b1; mem_addr = 5'd3; mem_data = 32'h33;
    step();
    mem_valid = 1'b0;
    wins = 0;
    fifo_cycle = -1;
    for (int i = 0; i < 12 && fifo_cycle < 0; i++) begin
      alu_addr = 5'(21 + i); alu_data = 32'(i);
      step();
      if (s_alu_ready) wins++;
      else fifo_cycle = i + 1;
    end
    chk("t3_alu_wins", wins, 8);
    chk("t3_fifo_cycle", fifo_cycle, 9);
    chk("t3_mem_addr", rf_addr, 3);
    chk("t3_mem_data", rf_data, 32'h33);
    step();
    chk("t3_alu_after", s_alu_ready, 1);
    idle();

    // full buffer pre-empts ALU, drains in push order
    for (int i = 0; i < 4; i++) issue(5'(12 + i));
    alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'h1111;
    for (int i = 0; i < 4; i++) begin
      mem_valid = 1'b1; mem_addr = 5'(12 + i); mem_data = 32'hA0 + 32'(i);
      step();
    end
    mem_valid = 1'b0;
    chk("t4_full_ready", mem_ready, 0);
    for (int i = 0; i < 40; i++) begin
      step();
      if (i == 0) chk("t4_full_win", s_alu_ready, 0);
      if (rf_wr && rf_addr >= 12 && rf_addr <= 15) got.push_back(rf_addr);
    end
    chk("t4_count", got.size(), 4);
    for (int i = 0; i < 4; i++) if (i < got.size()) chk("t4_order", got[i], 12 + i);
    idle();

    // register 0 through both paths
    alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'hCAFE;
    step();
    chk("t5_alu_r0_rdy", s_alu_ready, 1);
    chk("t5_alu_r0_wr", rf_wr, 0);
    issue(5'd0);
    q_addr1 = 5'd0; q_addr2 = 5'd0;
    #1;
    chk("t5_busy_r0", q_busy1, 0);
    mem_valid = 1'b1; mem_addr = 5'd0; mem_data = 32'hBEEF;
    step();
    mem_valid = 1'b0;
    step();
    chk("t5_mem_r0_wr", rf_wr, 0);

    // same-edge clear and re-issue: pending wins
    issue(5'd9);
    mem_valid = 1'b1; mem_addr = 5'd9; mem_data = 32'h99;
    step();
    mem_valid = 1'b0;
    ld_issue = 1'b1; ld_addr = 5'd9;
    step();
    ld_issue = 1'b0;
    q_addr1 = 5'd9;
    #1;
    chk("t5_set_wins", q_busy1, 1);
    chk("t5_set_wr", rf_addr, 9);

    // reset discards buffered loads
    for (int i = 0; i < 3; i++) issue(5'(10 + i));
    alu_valid = 1'b1; alu_addr = 5'd2; alu_data = 32'h2222;
    for (int i = 0; i < 3; i++) begin
      mem_valid = 1'b1; mem_addr = 5'(10 + i); mem_data = 32'hB0 + 32'(i);
      step();
    end
    q_addr1 = 5'd10; q_addr2 = 5'd11;
    do_reset();
    wrcnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (rf_wr) wrcnt++;
    end
    chk("t6_no_writes", wrcnt, 0);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if (!alu_valid || last_gnt == 1) begin
        alu_valid = ($urandom_range(0, 99) < 60);
        alu_addr  = 5'($urandom_range(0, 31));
        alu_data  = $urandom;
      end
      if (mem_valid && last_push) outst[mem_addr] = 1'b0;
      if (!mem_valid || last_push) begin
        mem_valid = 1'b0;
        cands.delete();
        for (int k = 1; k < 32; k++) if (outst[k]) cands.push_back(k);
        if (cands.size() > 0 && $urandom_range(0, 99) < 40) begin
          mem_valid = 1'b1;
          mem_addr  = 5'(cands[$urandom_range(0, cands.size() - 1)]);
          mem_data  = $urandom;
        end else if ($urandom_range(0, 99) < 3) begin
          mem_valid = 1'b1;
          mem_addr  = 5'd0;
          mem_data  = $urandom;
        end
      end
      ld_issue = 1'b0;
      if ($urandom_range(0, 99) < 30) begin
        ld_addr = 5'($urandom_range(0, 31));
        if (ld_addr == 0 || !m_busy[ld_addr]) ld_issue = 1'b1;
      end
      q_addr1 = 5'($urandom_range(0, 31));
      q_addr2 = 5'($urandom_range(0, 31));
      step();
      if (ld_issue && ld_addr != 0) outst[ld_addr] = 1'b1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
